// File: rtl/fir_sum_sat.sv
// Registered binary adder tree over TAPS signed products, followed by a
// round-half-up / saturate stage to Q1.15, with full-pipeline stall and saturation stats.
module fir_sum_sat #(
    parameter int TAPS   = 401,
    parameter int PROD_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [PROD_W-1:0] in_products [0:TAPS-1],
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [15:0]       out_sample,
    output logic                     sat_flag,
    output logic [15:0]              sat_count
);

    localparam int LEVELS = $clog2(TAPS);
    localparam int ACC_W  = PROD_W + LEVELS;

    localparam logic signed [ACC_W:0] C_HALF = (ACC_W+1)'(16384);
    localparam logic signed [ACC_W:0] C_MAX  = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0] C_MIN  = (ACC_W+1)'(-32768);

    // Number of nodes left after 'level' rounds of ceil-halving.
    function automatic int nodes_at(input int level);
        int n;
        n = TAPS;
        for (int l = 0; l < level; l++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

    logic                    r_out_valid;
    logic signed [15:0]      r_out_sample;
    logic                    r_sat_flag;
    logic [15:0]             r_sat_count;
    logic                    w_en;

    // One global enable: the whole pipeline moves or the whole pipeline holds.
    assign w_en     = !(r_out_valid && !out_ready);
    assign in_ready = w_en;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int N_IN  = nodes_at(k - 1);
        localparam int N_OUT = nodes_at(k);

        // Odd leftovers are paired with a zero, which passes them through unchanged.
        logic signed [ACC_W-1:0] w_pad  [0:2*N_OUT-1];
        logic signed [ACC_W-1:0] r_node [0:N_OUT-1];
        logic                    w_vin;
        logic                    r_valid;

        for (genvar j = 0; j < 2*N_OUT; j++) begin : g_pad
            if (j >= N_IN) begin : g_zero
                assign w_pad[j] = '0;
            end else if (k == 1) begin : g_ext
                assign w_pad[j] = {{LEVELS{in_products[j][PROD_W-1]}}, in_products[j]};
            end else begin : g_prev
                assign w_pad[j] = g_lvl[k-1].r_node[j];
            end
        end

        if (k == 1) begin : g_vin_first
            assign w_vin = in_valid;
        end else begin : g_vin_chain
            assign w_vin = g_lvl[k-1].r_valid;
        end

        // NOTE: data registers are reset too because the reset state of every
        // stage is defined as zero, not only the valid bits.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                for (int i = 0; i < N_OUT; i++) begin
                    r_node[i] <= '0;
                end
            end else if (w_en) begin
                // NOTE: non-blocking assignments so every stage samples the
                // pre-edge value of its predecessor.
                r_valid <= w_vin;
                for (int i = 0; i < N_OUT; i++) begin
                    r_node[i] <= w_pad[2*i] + w_pad[2*i+1];
                end
            end
        end
    end

    logic signed [ACC_W-1:0] w_tree_sum;
    logic                    w_tree_valid;
    logic signed [ACC_W:0]   w_biased;
    logic signed [ACC_W:0]   w_round;
    logic                    w_pos_sat;
    logic                    w_neg_sat;
    logic signed [15:0]      w_sample;

    assign w_tree_sum   = g_lvl[LEVELS].r_node[0];
    assign w_tree_valid = g_lvl[LEVELS].r_valid;

    always_comb begin
        // NOTE: every variable gets a value on every path, so no latch is inferred.
        w_biased  = $signed({w_tree_sum[ACC_W-1], w_tree_sum}) + C_HALF;
        w_round   = w_biased >>> 15;
        w_pos_sat = (w_round > C_MAX);
        w_neg_sat = (w_round < C_MIN);
        w_sample  = w_round[15:0];
        if (w_pos_sat) begin
            w_sample = 16'sh7FFF;
        end else if (w_neg_sat) begin
            w_sample = 16'sh8000;
        end
    end

    // Saturation is counted only on the edge that moves a sample into the output
    // register, so a stalled sample is never counted twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_sat_flag   <= 1'b0;
            r_sat_count  <= '0;
        end else if (w_en) begin
            r_out_valid  <= w_tree_valid;
            r_out_sample <= w_sample;
            if (w_tree_valid && (w_pos_sat || w_neg_sat)) begin
                r_sat_flag <= 1'b1;
                if (r_sat_count != 16'hFFFF) begin
                    r_sat_count <= r_sat_count + 16'd1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;
    assign sat_flag   = r_sat_flag;
    assign sat_count  = r_sat_count;

endmodule

// File: tb/tb_fir_sum_sat.sv
// Self-checking bench for fir_sum_sat: directed rounding/saturation cases plus
// randomized back-pressure traffic against an arithmetic reference model.
module tb_fir_sum_sat;

    localparam int TAPS = 401;
    localparam int LAT  = 10;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic signed [31:0]  prod [0:TAPS-1];
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic signed [15:0]  out_sample;
    logic                sat_flag;
    logic [15:0]         sat_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sat_count = 0;

    fir_sum_sat #(.TAPS(TAPS), .PROD_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_products(prod),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .sat_flag   (sat_flag),
        .sat_count  (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic longint set_sum();
        longint s;
        s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(prod[i]);
        return s;
    endfunction

    function automatic longint rounded(input longint s);
        return (s + 64'sd16384) >>> 15;
    endfunction

    function automatic logic [15:0] ref_q15(input longint s);
        longint r;
        r = rounded(s);
        if (r > 64'sd32767) return 16'h7FFF;
        if (r < -64'sd32768) return 16'h8000;
        return r[15:0];
    endfunction

    function automatic bit ref_sat(input longint s);
        longint r;
        r = rounded(s);
        return (r > 64'sd32767) || (r < -64'sd32768);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_set();
        for (int i = 0; i < TAPS; i++) prod[i] = '0;
    endtask

    task automatic fill_set(input logic [31:0] v);
        for (int i = 0; i < TAPS; i++) prod[i] = v;
    endtask

    task automatic rand_set();
        int mode;
        mode = $urandom_range(0, 2);
        for (int i = 0; i < TAPS; i++) begin
            prod[i] = $signed($urandom);
            if (mode == 0) prod[i] = prod[i] >>> 14;
            else if (mode == 1) prod[i] = prod[i] >>> 6;
        end
    endtask

    task automatic bump_sat();
        if (exp_sat_count < 65535) exp_sat_count++;
    endtask

    // Present the current set for one cycle with out_ready=1 and wait for its output.
    task automatic run_single(output logic [15:0] got, output int lat);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 4*LAT) begin
            tick();
            lat++;
        end
        got = out_sample;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        zero_set();
        rst = 1'b1;
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_sample !== 16'sh0000) begin n_errors++; $display("FAIL reset_out_sample: got %h want 0000", out_sample); end
        n_checks++; if (sat_flag !== 1'b0) begin n_errors++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
        n_checks++; if (sat_count !== 16'h0000) begin n_errors++; $display("FAIL reset_sat_count: got %h want 0000", sat_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        exp_sat_count = 0;
    endtask

    task automatic test_impulse();
        logic [15:0] got;
        int lat;
        zero_set();
        prod[0] = 32'sh40000000;
        run_single(got, lat);
        bump_sat();
        n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL impulse_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (got !== 16'h7FFF) begin n_errors++; $display("FAIL impulse_sample: got %h want 7fff", got); end
        n_checks++; if (sat_flag !== 1'b1) begin n_errors++; $display("FAIL impulse_sat_flag: got %b want 1", sat_flag); end
        n_checks++; if (sat_count !== 16'(exp_sat_count)) begin n_errors++; $display("FAIL impulse_sat_count: got %0d want %0d", sat_count, exp_sat_count); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL impulse_single_output: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_rounding();
        logic [31:0] vals [8];
        logic [15:0] exps [8];
        bit          sats [8];
        logic [15:0] got;
        int          lat;
        vals = '{32'h00004000, 32'h00003FFF, 32'hFFFFC000, 32'hFFFFBFFF,
                 32'h3FFFBFFF, 32'h3FFFC000, 32'hBFFFC000, 32'hBFFFBFFF};
        exps = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF,
                 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        sats = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            zero_set();
            prod[5] = vals[i];
            run_single(got, lat);
            if (sats[i]) bump_sat();
            n_checks++; if (got !== exps[i]) begin n_errors++; $display("FAIL rounding_%0d: product %h got %h want %h", i, vals[i], got, exps[i]); end
            n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL rounding_latency_%0d: got %0d want %0d", i, lat, LAT); end
            n_checks++; if (sat_count !== 16'(exp_sat_count)) begin n_errors++; $display("FAIL rounding_sat_count_%0d: got %0d want %0d", i, sat_count, exp_sat_count); end
            tick();
        end
    endtask

    task automatic test_neg_sat();
        int accepted;
        int outs;
        accepted = 0;
        outs     = 0;
        fill_set(32'hC0000000);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && outs < 3; cyc++) begin
            in_valid = (accepted < 3);
            #1;
            if (in_valid && in_ready) begin
                accepted++;
                bump_sat();
            end
            if (out_valid && out_ready) begin
                outs++;
                n_checks++; if (out_sample !== 16'sh8000) begin n_errors++; $display("FAIL neg_sat_sample_%0d: got %h want 8000", outs, out_sample); end
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (outs !== 3) begin n_errors++; $display("FAIL neg_sat_outputs: got %0d want 3", outs); end
        n_checks++; if (sat_count !== 16'(exp_sat_count)) begin n_errors++; $display("FAIL neg_sat_count: got %0d want %0d", sat_count, exp_sat_count); end
    endtask

    task automatic test_stall_hold();
        logic [15:0] q [$];
        logic [15:0] e;
        longint      s;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            rand_set();
            in_valid = 1'b1;
            #1;
            if (!in_ready) break;
            s = set_sum();
            q.push_back(ref_q15(s));
            if (ref_sat(s)) bump_sat();
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (q.size() !== LAT) begin n_errors++; $display("FAIL stall_fill_depth: accepted %0d want %0d", q.size(), LAT); end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready_%0d: got %b want 0", c, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_out_valid_%0d: got %b want 1", c, out_valid); end
            if (q.size() > 0) begin
                n_checks++; if (out_sample !== q[0]) begin n_errors++; $display("FAIL stall_hold_sample_%0d: got %h want %h", c, out_sample, q[0]); end
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            #1;
            e = (q.size() > 0) ? q.pop_front() : 16'hXXXX;
            n_checks++; if (out_valid !== 1'b1 || out_sample !== e) begin n_errors++; $display("FAIL stall_release_%0d: valid %b sample %h want 1/%h", i, out_valid, out_sample, e); end
            tick();
        end
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stall_release_extra: out_valid got %b want 0", out_valid); end
        n_checks++; if (sat_count !== 16'(exp_sat_count)) begin n_errors++; $display("FAIL stall_sat_count: got %0d want %0d", sat_count, exp_sat_count); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] q [$];
        logic [15:0] e;
        longint      s;
        int          sent;
        int          received;
        int          cyc;
        sent     = 0;
        received = 0;
        cyc      = 0;
        while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                rand_set();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (in_valid && in_ready) begin
                s = set_sum();
                q.push_back(ref_q15(s));
                if (ref_sat(s)) bump_sat();
                sent++;
            end
            if (out_valid && out_ready) begin
                received++;
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL b2b_extra_output: sample %h with nothing outstanding", out_sample);
                end else begin
                    e = q.pop_front();
                    if (out_sample !== e) begin n_errors++; $display("FAIL b2b_sample_%0d: got %h want %h", received, out_sample, e); end
                end
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (received !== 1000) begin n_errors++; $display("FAIL b2b_count: got %0d want 1000 (cycles %0d)", received, cyc); end
        n_checks++; if (q.size() !== 0) begin n_errors++; $display("FAIL b2b_outstanding: %0d samples never emerged", q.size()); end
        n_checks++; if (sat_count !== 16'(exp_sat_count)) begin n_errors++; $display("FAIL b2b_sat_count: got %0d want %0d", sat_count, exp_sat_count); end
        n_checks++; if (sat_flag !== (exp_sat_count > 0)) begin n_errors++; $display("FAIL b2b_sat_flag: got %b want %b", sat_flag, exp_sat_count > 0); end
    endtask

    task automatic test_async_reset();
        logic [15:0] got;
        int          lat;
        int          ghosts;
        int          w;
        fill_set(32'h40000000);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            #1;
            tick();
        end
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 30) begin
            tick();
            w++;
        end
        n_checks++; if (out_valid !== 1'b1 || sat_flag !== 1'b1) begin n_errors++; $display("FAIL areset_prefill: valid %b sat_flag %b want 1/1", out_valid, sat_flag); end
        #2;
        rst = 1'b1;
        #1;
        exp_sat_count = 0;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (sat_flag !== 1'b0) begin n_errors++; $display("FAIL areset_sat_flag: got %b want 0", sat_flag); end
        n_checks++; if (sat_count !== 16'h0000) begin n_errors++; $display("FAIL areset_sat_count: got %h want 0000", sat_count); end
        n_checks++; if (out_sample !== 16'sh0000) begin n_errors++; $display("FAIL areset_out_sample: got %h want 0000", out_sample); end
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        ghosts    = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_valid) ghosts++;
        end
        n_checks++; if (ghosts !== 0) begin n_errors++; $display("FAIL areset_discard: got %0d stale outputs want 0", ghosts); end
        zero_set();
        prod[3] = 32'sh00008000;
        run_single(got, lat);
        n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL areset_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (got !== 16'h0001) begin n_errors++; $display("FAIL areset_sample: got %h want 0001", got); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL areset_single_output: out_valid got %b want 0", out_valid); end
        n_checks++; if (sat_count !== 16'(exp_sat_count)) begin n_errors++; $display("FAIL areset_sat_count_after: got %0d want %0d", sat_count, exp_sat_count); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        zero_set();
        test_reset();
        test_impulse();
        test_rounding();
        test_neg_sat();
        test_stall_hold();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
